// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int MEM_LATENCY = 4;
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);
    localparam logic TGT_I = 1'b0;
    localparam logic TGT_D = 1'b1;
    typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache request, memory bus and fill signals of the arbiter
interface mem_arbiter_if;
    import mem_arb_pkg::*;
    logic              imiss;
    logic [ADDR_W-1:0] iaddr;
    logic              dmiss;
    logic [ADDR_W-1:0] daddr;
    logic              dwrite_req;
    logic [DATA_W-1:0] dwrite_data;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              fill_we;
    logic              fill_tag_we;
    logic              fill_target;
    logic [CNT_W-1:0]  fill_word;
    logic [DATA_W-1:0] fill_data;
    logic              ibusy;
    logic              dbusy;
    logic              dwrite_ack;
    modport master (
        input  imiss, iaddr, dmiss, daddr, dwrite_req, dwrite_data, mem_data_valid, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_tag_we, fill_target,
               fill_word, fill_data, ibusy, dbusy, dwrite_ack
    );
    modport slave (
        output imiss, iaddr, dmiss, daddr, dwrite_req, dwrite_data, mem_data_valid, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_tag_we, fill_target,
               fill_word, fill_data, ibusy, dbusy, dwrite_ack
    );
endinterface

// File: rtl/fill_sequencer.sv
// fill_sequencer: block base latch, issue/return counters and completion for one cache fill
module fill_sequencer
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              active_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              valid_i,
    output logic              issue_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CNT_W-1:0]  word_o,
    output logic              done_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d, rcnt_q, rcnt_d;
    logic              issued_q, issued_d;
    assign issue_o = active_i & ~issued_q;
    assign addr_o  = base_q | ADDR_W'({icnt_q, 1'b0});
    assign word_o  = active_i ? rcnt_q : '0;
    assign done_o  = active_i & valid_i & (rcnt_q == LAST);
    // Latch the block base on start; counters saturate at the last word so addresses stay in the block
    always_comb begin
        base_d   = start_i ? addr_i & ~OFFSET_MASK : base_q;
        icnt_d   = start_i ? '0 : (issue_o && icnt_q != LAST) ? icnt_q + 1'b1 : icnt_q;
        issued_d = start_i ? 1'b0 : issued_q | (issue_o & (icnt_q == LAST));
        rcnt_d   = start_i ? '0 : (active_i && valid_i && rcnt_q != LAST) ? rcnt_q + 1'b1 : rcnt_q;
    end
    // Sequencer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            icnt_q   <= '0;
            rcnt_q   <= '0;
            issued_q <= 1'b0;
        end else begin
            base_q   <= base_d;
            icnt_q   <= icnt_d;
            rcnt_q   <= rcnt_d;
            issued_q <= issued_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares main memory between icache fills, dcache fills and write-through stores
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    state_t            state_q, state_d;
    logic              ack_q, ack_d;
    logic              start, fill_active, issue, done;
    logic [ADDR_W-1:0] req_addr, seq_addr;
    logic [CNT_W-1:0]  word;
    // Next state: store beats dmiss beats imiss; a store being acknowledged is not taken again
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (bus.dwrite_req && !ack_q) ? WRITE : bus.dmiss ? FILL_D : bus.imiss ? FILL_I : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = done ? IDLE : state_q;
        endcase
        ack_d = state_q == WRITE;
    end
    assign start       = (state_q == IDLE) && (state_d == FILL_I || state_d == FILL_D);
    assign req_addr    = (state_d == FILL_D) ? bus.daddr : bus.iaddr;
    assign fill_active = (state_q == FILL_I) || (state_q == FILL_D);
    fill_sequencer u_seq (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .active_i (fill_active),
        .addr_i   (req_addr),
        .valid_i  (bus.mem_data_valid),
        .issue_o  (issue),
        .addr_o   (seq_addr),
        .word_o   (word),
        .done_o   (done)
    );
    assign bus.mem_en      = (state_q == WRITE) | issue;
    assign bus.mem_wr      = state_q == WRITE;
    assign bus.mem_addr    = (state_q == WRITE) ? bus.daddr : issue ? seq_addr : '0;
    assign bus.mem_wdata   = (state_q == WRITE) ? bus.dwrite_data : '0;
    assign bus.fill_we     = fill_active & bus.mem_data_valid;
    assign bus.fill_tag_we = done;
    assign bus.fill_target = (state_q == FILL_D) ? TGT_D : TGT_I;
    assign bus.fill_word   = word;
    assign bus.fill_data   = bus.mem_rdata;
    assign bus.ibusy       = bus.imiss | (state_q == FILL_I);
    assign bus.dbusy       = bus.dwrite_req | bus.dmiss | (state_q == WRITE) | (state_q == FILL_D);
    assign bus.dwrite_ack  = ack_q;
    // State and acknowledge registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random cache traffic against a transaction-level model of the arbiter
module tb_mem_arbiter;
    import mem_arb_pkg::*;
    localparam int NCYC = 3000;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
    int checks = 0;
    int errs = 0;
    int cyc = 0;
    int m_kind = 0;
    int m_start = 0;
    int m_ret = 0;
    int ack_due = -10;
    int hold = 0;
    int fills = 0;
    int k;
    int r;
    logic [15:0] m_base = '0;
    bit mv [8];
    logic [15:0] md [8];
    bit saw_itag, saw_dtag, saw_ack;
    logic fill, e_en, e_wr, e_we, e_tag, e_tgt, e_ack, e_ib, e_db;
    logic [15:0] e_addr, e_wdata;
    logic [2:0] e_word;
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask
    initial begin
        rst = 1'b1;
        bus.imiss = 0; bus.iaddr = 0; bus.dmiss = 0; bus.daddr = 0;
        bus.dwrite_req = 0; bus.dwrite_data = 0; bus.mem_data_valid = 0; bus.mem_rdata = 0;
        saw_itag = 0; saw_dtag = 0; saw_ack = 0;
        for (int i = 0; i < 8; i++) begin
            mv[i] = 0;
            md[i] = 0;
        end
        repeat (2) @(posedge clk);
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            bus.mem_data_valid = mv[c % 8];
            bus.mem_rdata = md[c % 8];
            mv[c % 8] = 0;
            if (!bus.mem_data_valid && m_kind < 2 && $urandom_range(15) == 0) begin
                bus.mem_data_valid = 1;
                bus.mem_rdata = 16'($urandom);
            end
            if (hold > 0) hold--;
            rst = (c > 20 && hold == 0 && $urandom_range(399) == 0);
            if (rst) begin
                hold = 6;
                bus.imiss = 0;
                bus.dmiss = 0;
                bus.dwrite_req = 0;
            end else if (hold == 0) begin
                if (bus.imiss && (saw_itag || $urandom_range(31) == 0)) bus.imiss = 0;
                else if (!bus.imiss && $urandom_range(7) == 0) begin
                    bus.imiss = 1;
                    bus.iaddr = 16'($urandom);
                end
                if (bus.dmiss && (saw_dtag || $urandom_range(31) == 0)) bus.dmiss = 0;
                if (bus.dwrite_req && saw_ack) bus.dwrite_req = 0;
                if (!bus.dmiss && !bus.dwrite_req && $urandom_range(5) == 0) begin
                    r = $urandom_range(2);
                    bus.daddr = 16'($urandom);
                    bus.dwrite_data = 16'($urandom);
                    bus.dmiss = r != 0;
                    bus.dwrite_req = r != 1;
                end
            end
            @(negedge clk);
            fill = m_kind >= 2;
            k = c - m_start;
            e_en = (m_kind == 1) || (fill && k < 8);
            e_wr = m_kind == 1;
            e_addr = (m_kind == 1) ? bus.daddr : (fill && k < 8) ? m_base + 16'(2 * k) : 16'h0;
            e_wdata = (m_kind == 1) ? bus.dwrite_data : 16'h0;
            e_we = fill && bus.mem_data_valid;
            e_tag = e_we && m_ret == 7;
            e_tgt = m_kind == 3;
            e_word = fill ? 3'(m_ret) : 3'd0;
            e_ack = ack_due == c;
            e_ib = bus.imiss || m_kind == 2;
            e_db = bus.dwrite_req || bus.dmiss || m_kind == 1 || m_kind == 3;
            check_eq("mem_en", bus.mem_en, e_en);
            check_eq("mem_wr", bus.mem_wr, e_wr);
            check_eq("mem_addr", bus.mem_addr, e_addr);
            check_eq("mem_wdata", bus.mem_wdata, e_wdata);
            check_eq("fill_we", bus.fill_we, e_we);
            check_eq("fill_tag_we", bus.fill_tag_we, e_tag);
            check_eq("fill_target", bus.fill_target, e_tgt);
            check_eq("fill_word", bus.fill_word, e_word);
            check_eq("dwrite_ack", bus.dwrite_ack, e_ack);
            check_eq("ibusy", bus.ibusy, e_ib);
            check_eq("dbusy", bus.dbusy, e_db);
            if (e_we) check_eq("fill_data", bus.fill_data, bus.mem_rdata);
            if (e_tag) fills++;
            saw_itag = bus.fill_tag_we && !bus.fill_target;
            saw_dtag = bus.fill_tag_we && bus.fill_target;
            saw_ack = bus.dwrite_ack;
            if (bus.mem_en && !bus.mem_wr) begin
                mv[(c + 4) % 8] = 1;
                md[(c + 4) % 8] = 16'($urandom);
            end
            if (rst) begin
                m_kind = 0;
                ack_due = -10;
            end else if (m_kind == 0) begin
                if (bus.dwrite_req && ack_due != c) begin
                    m_kind = 1;
                    ack_due = c + 2;
                end else if (bus.dmiss || bus.imiss) begin
                    m_kind = bus.dmiss ? 3 : 2;
                    m_start = c + 1;
                    m_base = (bus.dmiss ? bus.daddr : bus.iaddr) & 16'hFFF0;
                    m_ret = 0;
                end
            end else if (m_kind == 1) m_kind = 0;
            else if (bus.mem_data_valid) begin
                if (m_ret == 7) m_kind = 0;
                else m_ret++;
            end
        end
        check_eq("fills_completed", fills > 20, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single multi-cycle main memory between instruction-cache fills, data-cache fills and data-cache write-through stores in the 16-bit pipelined CPU. It sequences each block fill:
- issues one word address per cycle;
- counts returning words;
- drives the data and tag write enables of the cache being filled.

It asserts per-side busy so the fetch and memory stages stall while their request is outstanding.

## Interface
- ADDR_W, 16, address width (byte addresses)
- DATA_W, 16, memory word width
- WORDS_PER_BLOCK, 8, words per cache block (16-byte block)
- MEM_LATENCY, 4, cycles from mem_en to mem_data_valid; memory is pipelined and accepts one read per cycle

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- imiss  in  1  icache miss pending
- iaddr  in  ADDR_W  icache miss address
- dmiss  in  1  dcache miss pending
- daddr  in  ADDR_W  dcache miss / store address
- dwrite_req  in  1  dcache write-through store pending
- dwrite_data  in  DATA_W  store data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  memory write (valid with mem_en)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_data_valid  in  1  read data valid from memory
- mem_rdata  in  DATA_W  read data from memory
- fill_we  out  1  write fill_data into target cache data array
- fill_tag_we  out  1  write tag/valid of target cache block
- fill_target  out  1  0 = icache, 1 = dcache
- fill_word  out  3  word index within block
- fill_data  out  DATA_W  word to write (mem_rdata)
- ibusy  out  1  stall fetch
- dbusy  out  1  stall memory stage
- dwrite_ack  out  1  one-cycle pulse, store committed

## Operation
- States: IDLE, WRITE, FILL_I, FILL_D.
- In IDLE, priority is dwrite_req > dmiss > imiss, sampled at the clock edge.
- WRITE lasts one cycle:
  - mem_en=1, mem_wr=1, mem_addr=daddr, mem_wdata=dwrite_data.
  - dwrite_ack pulses the following cycle; the block then returns to IDLE.
- FILL_x:
  - Base address is the request address with bits [3:0] zeroed, latched on entry.
  - An issue counter (0..7) drives mem_addr = base + 2*count with mem_en=1, mem_wr=0 for 8 consecutive cycles, then holds mem_en=0.
  - A return counter (0..7) advances on each mem_data_valid.
  - fill_we = mem_data_valid in FILL_x, combinational; fill_word = return counter; fill_data = mem_rdata; fill_target = state side.
  - fill_tag_we is asserted in the same cycle as the 8th fill_we. The next state is IDLE.
- Counters saturate and never wrap; addresses never cross the block.
- Once a request is latched it completes even if imiss/dmiss deasserts.
- mem_data_valid in IDLE or WRITE is ignored: no fill_we.
- dbusy = dwrite_req | dmiss | state in {WRITE, FILL_D}. ibusy = imiss | state==FILL_I.
- Busy flags drop in the cycle after fill_tag_we or dwrite_ack, unless the request input is still high.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, base 0.
- Fill timeline, with the request sampled at edge 0:
  - cycles 1–8: mem_en;
  - cycles 5–12: data (MEM_LATENCY=4);
  - cycle 12: fill_tag_we;
  - cycle 13: IDLE, and a queued request is sampled at the end of cycle 13.
- Store: mem_wr in cycle 1, dwrite_ack in cycle 2.
- Simultaneous imiss and dmiss: the D fill runs first; the I fill begins issuing 2 cycles after the D fill_tag_we.
- rst during any state: next edge returns to IDLE with all outputs 0. Late mem_data_valid pulses are then ignored.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, WRITE, FILL_I, FILL_D);
  - WORDS_PER_BLOCK, the block offset mask and the FILL_I/FILL_D target encoding.
- Sub-module fill_sequencer holds the issue counter, return counter, base latch and done flag. It is instantiated once and shared by both fill states.

## Test plan
- imiss with iaddr=0x1234 alone → mem_addr 0x1230,0x1232,…,0x123E in cycles 1–8; fill_word 0..7 in cycles 5–12; fill_tag_we and fill_target=0 in cycle 12; ibusy low in cycle 13.
- imiss 0x0040 and dmiss 0x8006 in the same cycle → D fill of 0x8000–0x800E first (fill_target=1); I fill of 0x0040 issues starting cycle 14; ibusy high throughout.
- dwrite_req daddr=0x2002 data=0xBEEF with dmiss asserted → cycle 1: mem_wr=1, addr 0x2002, wdata 0xBEEF; cycle 2: dwrite_ack; D fill follows.
- rst asserted in cycle 6 of an I fill → all outputs 0 in cycle 7; remaining mem_data_valid pulses produce no fill_we or fill_tag_we.
- imiss dropped after cycle 2 → all 8 words and fill_tag_we still delivered.
- mem_data_valid pulse while IDLE → fill_we stays 0 and state is unchanged.
